// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes, FSM states,
// instruction classes, pc_src selects and error codes.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_t;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_JR      = 4'd1,
    CLS_J       = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_class_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_RS     = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Control-flow classes finish in EXEC with their own PC update.
  function automatic logic is_ctrl_flow(input instr_class_t cls);
    return (cls == CLS_JR) || (cls == CLS_J) || (cls == CLS_JAL) || (cls == CLS_BRANCH);
  endfunction

  function automatic logic is_mem_op(input instr_class_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer (master) and the
// memories/datapath (slave). Also carries the FSM state for debug visibility.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  import cpu_pkg::*;

  logic             run;
  logic             clear;
  logic [5:0]       opecode;
  logic [5:0]       funct;
  logic             br_taken;
  logic             imem_valid;
  logic             dmem_ready;

  logic             imem_req;
  logic             ir_we;
  logic             write_pc;
  logic [1:0]       pc_src;
  logic             write_reg;
  logic             write_lr;
  logic             dmem_re;
  logic             dmem_we;
  logic             busy;
  logic             halted;
  logic [1:0]       err;
  logic [CNT_W-1:0] instr_count;
  seq_state_t       state;

  // Handshakes: a request (imem_req, dmem_re, dmem_we) stays high until the
  // responder's completion (imem_valid, dmem_ready) is high in the same cycle;
  // the transfer happens on that clock edge and the request drops afterwards.
  modport master (
    input  run, clear, opecode, funct, br_taken, imem_valid, dmem_ready,
    output imem_req, ir_we, write_pc, pc_src, write_reg, write_lr,
           dmem_re, dmem_we, busy, halted, err, instr_count, state
  );

  modport slave (
    output run, clear, opecode, funct, br_taken, imem_valid, dmem_ready,
    input  imem_req, ir_we, write_pc, pc_src, write_reg, write_lr,
           dmem_re, dmem_we, busy, halted, err, instr_count, state
  );

endinterface

// File: rtl/seq_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [5:0]   opecode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opecode)
      OP_RTYPE: cls = (funct == FN_JR) ? CLS_JR : CLS_ALU;
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      OP_BEQ,
      OP_BNE:   cls = CLS_BRANCH;
      OP_ADDI,
      OP_SLTI,
      OP_ANDI,
      OP_ORI:   cls = CLS_ALU;
      OP_LW:    cls = CLS_LOAD;
      OP_SW:    cls = CLS_STORE;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the single-issue core.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input logic                    clk,
  input logic                    rstn,
  multicycle_sequencer_if.master bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  seq_state_t   state;
  seq_state_t   boundary;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]   err_q;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic         mem_done;
  logic         retire;
  logic [1:0]   pc_src_c;

  seq_decode u_decode (
    .opecode (bus.opecode),
    .funct   (bus.funct),
    .cls     (dec_cls)
  );

  // run is only sampled at an instruction boundary, never mid-instruction.
  assign boundary = bus.run ? S_FETCH : S_IDLE;
  assign mem_done = (state == S_MEM) && bus.dmem_ready;

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC:  retire = is_ctrl_flow(cls_q);
      S_MEM:   retire = mem_done && (cls_q == CLS_STORE);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      to_cnt <= '0;
      err_q  <= ERR_NONE;
      cls_q  <= CLS_ALU;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_valid) begin
            state  <= S_DECODE;
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state  <= S_HALT;
            err_q  <= ERR_TIMEOUT;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          case (dec_cls)
            CLS_HALT:    state <= S_HALT;
            CLS_ILLEGAL: begin
              state <= S_HALT;
              err_q <= ERR_ILLEGAL;
            end
            default:     state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (is_ctrl_flow(cls_q))   state <= boundary;
          else if (is_mem_op(cls_q)) state <= S_MEM;
          else                       state <= S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            state  <= (cls_q == CLS_STORE) ? boundary : S_WB;
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state  <= S_HALT;
            err_q  <= ERR_TIMEOUT;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_WB: begin
          state <= boundary;
        end
        S_HALT: begin
          if (bus.clear) begin
            state <= S_IDLE;
            err_q <= ERR_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PC source only matters on cycles that pulse write_pc; it rests at pc+4.
  always_comb begin
    pc_src_c = PC_SEQ;
    if (state == S_EXEC) begin
      case (cls_q)
        CLS_JR:      pc_src_c = PC_RS;
        CLS_J,
        CLS_JAL:     pc_src_c = PC_JUMP;
        CLS_BRANCH:  pc_src_c = bus.br_taken ? PC_BRANCH : PC_SEQ;
        default:     pc_src_c = PC_SEQ;
      endcase
    end
  end

  assign bus.imem_req  = (state == S_FETCH);
  assign bus.ir_we     = (state == S_FETCH) && bus.imem_valid;
  assign bus.write_pc  = retire;
  assign bus.pc_src    = pc_src_c;
  assign bus.write_reg = (state == S_WB);
  assign bus.write_lr  = (state == S_EXEC) && (cls_q == CLS_JAL);
  assign bus.dmem_re   = (state == S_MEM) && (cls_q == CLS_LOAD);
  assign bus.dmem_we   = (state == S_MEM) && (cls_q == CLS_STORE);
  assign bus.busy      = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted    = (state == S_HALT);
  assign bus.err       = err_q;
  assign bus.state     = state;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       count_q <= '0;
    else if (retire) count_q <= count_q + CNT_W'(1);
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a per-instruction behavioural
// model builds cycle-by-cycle stimulus and expected-output queues.
module tb_multicycle_sequencer;
  import cpu_pkg::*;

  localparam int MEM_TO = 4;
  localparam int CNT_W  = 32;
  localparam int VW     = 11;
  localparam int SW     = 4;

  typedef enum int {K_ALU, K_JR, K_J, K_JAL, K_BR, K_LW, K_SW, K_HALT, K_ILL} kind_t;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(
    .MEM_TIMEOUT (MEM_TO),
    .TO_W        (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [VW-1:0]    exp_q[$];
  logic [SW-1:0]    stim_q[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] m_count = '0;
  logic [1:0]       m_err   = 2'b00;
  int               m_after = 1;   // 0: fetching next, 1: idle, 2: halted

  // Output vector: {imem_req, ir_we, write_pc, pc_src, write_reg, write_lr, dmem_re, dmem_we, busy, halted}
  function automatic logic [VW-1:0] ov(input logic req, input logic irw, input logic wpc,
                                       input logic [1:0] src, input logic wreg, input logic wlr,
                                       input logic re, input logic we, input logic bsy, input logic hlt);
    return {req, irw, wpc, src, wreg, wlr, re, we, bsy, hlt};
  endfunction

  // Stimulus vector: {run, imem_valid, dmem_ready, clear}
  function automatic logic [SW-1:0] st(input logic r, input logic iv, input logic dr, input logic clr);
    return {r, iv, dr, clr};
  endfunction

  function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? K_JR : K_ALU;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b000100, 6'b000101: return K_BR;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return K_ALU;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b111111: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef INSTR_COUNT_EN
    return m_count;
`else
    return '0;
`endif
  endfunction

  task automatic push(input logic [SW-1:0] s, input logic [VW-1:0] v);
    stim_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic retire_model(input logic run_end);
    m_count = m_count + 1;
    m_after = run_end ? 0 : 1;
  endtask

  // ---------------- reference model ----------------
  // fw/mw: cycles the memory keeps valid/ready low; run_end: run level from EXEC on.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic br,
                             input int fw, input int mw, input logic run_end);
    kind_t k;
    logic [1:0] src;
    k = kind_of(op, fn);
    bus.opecode  = op;
    bus.funct    = fn;
    bus.br_taken = br;
    if (m_after == 1) push(st(1,0,0,0), ov(0,0,0,2'b00,0,0,0,0,0,0));
    m_after = 0;
    for (int i = 0; i < MEM_TO; i++) begin
      if (i >= fw) begin
        push(st(1,1,0,0), ov(1,1,0,2'b00,0,0,0,0,1,0));
        break;
      end
      push(st(1,0,0,0), ov(1,0,0,2'b00,0,0,0,0,1,0));
      if (i == MEM_TO - 1) begin
        m_err = 2'b10;
        m_after = 2;
        return;
      end
    end
    push(st(1,0,0,0), ov(0,0,0,2'b00,0,0,0,0,1,0));
    if (k == K_HALT) begin
      m_after = 2;
      return;
    end
    if (k == K_ILL) begin
      m_err = 2'b01;
      m_after = 2;
      return;
    end
    if (k == K_JR || k == K_J || k == K_JAL || k == K_BR) begin
      src = (k == K_JR) ? 2'b01 : (k == K_BR) ? (br ? 2'b11 : 2'b00) : 2'b10;
      push(st(run_end,0,0,0), ov(0,0,1,src,0,(k == K_JAL),0,0,1,0));
      retire_model(run_end);
      return;
    end
    push(st(1,0,0,0), ov(0,0,0,2'b00,0,0,0,0,1,0));
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < MEM_TO; i++) begin
        if (i >= mw) begin
          push(st(run_end,0,1,0), ov(0,0,(k == K_SW),2'b00,0,0,(k == K_LW),(k == K_SW),1,0));
          break;
        end
        push(st(run_end,0,0,0), ov(0,0,0,2'b00,0,0,(k == K_LW),(k == K_SW),1,0));
        if (i == MEM_TO - 1) begin
          m_err = 2'b10;
          m_after = 2;
          return;
        end
      end
      if (k == K_SW) begin
        retire_model(run_end);
        return;
      end
    end
    push(st(run_end,0,0,0), ov(0,0,1,2'b00,1,0,0,0,1,0));
    retire_model(run_end);
  endtask

  // HALT: one cycle holding, one cycle clear; then clear while IDLE does nothing.
  task automatic model_clear();
    push(st(0,0,0,0), ov(0,0,0,2'b00,0,0,0,0,0,1));
    push(st(0,0,0,1), ov(0,0,0,2'b00,0,0,0,0,0,1));
    push(st(0,0,0,1), ov(0,0,0,2'b00,0,0,0,0,0,0));
    m_err = 2'b00;
    m_after = 1;
  endtask

  // ---------------- driver / checker ----------------
  task automatic run_trace(input string name);
    int cyc;
    logic [SW-1:0] s;
    logic [VW-1:0] e;
    logic [VW-1:0] a;
    cyc = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {bus.run, bus.imem_valid, bus.dmem_ready, bus.clear} = s;
      #1;
      a = {bus.imem_req, bus.ir_we, bus.write_pc, bus.pc_src, bus.write_reg, bus.write_lr,
           bus.dmem_re, bus.dmem_we, bus.busy, bus.halted};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: outputs got %b want %b", name, cyc, a, e);
      end
      cyc++;
    end
  endtask

  task automatic end_check(input string name);
    @(posedge clk);
    #1;
    total++;
    if (bus.err !== m_err) begin
      bad++;
      $display("FAIL %s err: got %b want %b", name, bus.err, m_err);
    end
    total++;
    if (bus.instr_count !== exp_count()) begin
      bad++;
      $display("FAIL %s instr_count: got %0d want %0d", name, bus.instr_count, exp_count());
    end
    total++;
    if ({bus.busy, bus.halted} !== {(m_after == 0), (m_after == 2)}) begin
      bad++;
      $display("FAIL %s busy/halted: got %b%b want %b%b", name, bus.busy, bus.halted,
               (m_after == 0), (m_after == 2));
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic br, input int fw, input int mw, input logic run_end);
    model_instr(op, fn, br, fw, mw, run_end);
    run_trace(name);
    end_check(name);
  endtask

  task automatic do_clear(input string name);
    model_clear();
    run_trace(name);
    end_check(name);
  endtask

  task automatic check_all_zero(input string name);
    logic [VW-1:0] a;
    a = {bus.imem_req, bus.ir_we, bus.write_pc, bus.pc_src, bus.write_reg, bus.write_lr,
         bus.dmem_re, bus.dmem_we, bus.busy, bus.halted};
    total++;
    if (a !== '0) begin
      bad++;
      $display("FAIL %s outputs: got %b want 0", name, a);
    end
    total++;
    if (bus.err !== 2'b00 || bus.instr_count !== '0) begin
      bad++;
      $display("FAIL %s err/count: got %b/%0d want 00/0", name, bus.err, bus.instr_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    {bus.run, bus.imem_valid, bus.dmem_ready, bus.clear} = '0;
    bus.opecode = '0;
    bus.funct = '0;
    bus.br_taken = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    total++;
    if (bus.state !== S_IDLE) begin
      bad++;
      $display("FAIL reset state: got %0d want IDLE", bus.state);
    end
    rstn = 1'b1;
    m_count = '0;
    m_err = 2'b00;
    m_after = 1;
  endtask

  task automatic test_addi();
    do_instr("addi", 6'b001000, 6'($urandom_range(0, 63)), 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_load_store();
    do_instr("lw_wait3", 6'b100011, 6'd0, 1'b0, 0, 3, 1'b1);
    do_instr("sw_wait1", 6'b101011, 6'd0, 1'b0, 1, 1, 1'b1);
  endtask

  task automatic test_branches();
    do_instr("beq_taken", 6'b000100, 6'd0, 1'b1, 0, 0, 1'b1);
    do_instr("bne_not",   6'b000101, 6'd0, 1'b0, 2, 0, 1'b1);
    do_instr("jal",       6'b000011, 6'd0, 1'b0, 0, 0, 1'b1);
    do_instr("jr",        6'b000000, 6'b001000, 1'b0, 0, 0, 1'b1);
    do_instr("j",         6'b000010, 6'd0, 1'b1, 0, 0, 1'b1);
  endtask

  task automatic test_halt_illegal();
    do_instr("illegal", 6'b010111, 6'd0, 1'b0, 0, 0, 1'b1);
    do_clear("illegal_clear");
    do_instr("halt_op", 6'b111111, 6'd0, 1'b0, 0, 0, 1'b1);
    do_clear("halt_clear");
  endtask

  task automatic test_fetch_timeout();
    do_instr("fetch_to_edge", 6'b001101, 6'd0, 1'b0, MEM_TO - 1, 0, 1'b1);
    do_instr("fetch_timeout", 6'b001000, 6'd0, 1'b0, 10, 0, 1'b1);
    do_clear("fetch_to_clear");
    do_instr("mem_timeout",   6'b100011, 6'd0, 1'b0, 0, 10, 1'b1);
    do_clear("mem_to_clear");
  endtask

  task automatic test_run_drop();
    do_instr("run_drop_lw", 6'b100011, 6'd0, 1'b0, 0, 2, 1'b0);
    do_instr("run_drop_j",  6'b000010, 6'd0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wb();
    model_instr(6'b001010, 6'd0, 1'b0, 1, 0, 1'b1);
    run_trace("rst_wb_pre");
    {bus.run, bus.imem_valid, bus.dmem_ready, bus.clear} = '0;
    rstn = 1'b0;
    #1;
    check_all_zero("rst_mid_wb");
    m_count = '0;
    m_err = 2'b00;
    m_after = 1;
    @(negedge clk);
    rstn = 1'b1;
    do_instr("after_rst", 6'b001100, 6'd0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [5:0] ops [14];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{6'b000000, 6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000,
            6'b001010, 6'b001100, 6'b001101, 6'b100011, 6'b101011, 6'b111111, 6'b100011};
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 1) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
      do_instr("random", op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
               $urandom_range(0, 5), ($urandom_range(0, 3) != 0));
      if (m_after == 2) do_clear("random_clear");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_load_store();
    test_branches();
    test_halt_illegal();
    test_fetch_timeout();
    test_run_drop();
    test_reset_mid_wb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle FSM that sequences the single-issue core datapath: fetch, decode, execute, memory and writeback. It decodes opecode/funct from the instruction register and issues one-cycle write strobes (IR, PC, register file, link register) plus data-memory requests with a ready handshake. It replaces the free-running two-phase PC toggle and sits between the instruction/data memory interfaces and the ALU/register-file datapath.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting on imem_valid/dmem_ready before error halt (1..2^TO_W-1)
TO_W, 8, timeout counter width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
clear  in  1  pulse; leaves HALT to IDLE
opecode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
br_taken  in  1  branch condition from datapath (zflag^opecode[0])
imem_valid  in  1  instruction word available
dmem_ready  in  1  data access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  latch instruction register
write_pc  out  1  PC update strobe
pc_src  out  2  00 pc+4, 01 rs (jr), 10 jump target, 11 branch target
write_reg  out  1  register-file write strobe
write_lr  out  1  link-register write (jal)
dmem_re  out  1  data read request
dmem_we  out  1  data write request
busy  out  1  state not IDLE/HALT
halted  out  1  state HALT
err  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky until clear
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rstn=0): state IDLE, timeout counter 0, err 00, instr_count 0; all strobe/request outputs 0. Outputs are decoded combinationally from the state register and inputs, so all are 0 in IDLE.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: run=1 -> FETCH next cycle.
- FETCH: imem_req=1; ir_we=imem_valid. On imem_valid -> DECODE. Each waiting cycle increments the timeout counter; at MEM_TIMEOUT -> HALT, err=10.
- DECODE: one cycle. 111111 -> HALT (normal halt, err unchanged). Unsupported opcode -> HALT, err=01. Otherwise -> EXEC.
- Supported: R-type 000000, jr (000000/001000), j 000010, jal 000011, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, lw 100011, sw 101011.
- EXEC, jumps and branches: write_pc=1 this cycle. jr pc_src=01; j pc_src=10; jal pc_src=10 with write_lr=1; beq/bne pc_src=11 if br_taken else 00. Instruction retires -> boundary.
- EXEC, ALU ops: -> WB. lw/sw -> MEM.
- MEM: dmem_re (lw) or dmem_we (sw) held high until dmem_ready, same timeout rule as FETCH. On ready: lw -> WB; sw asserts write_pc, pc_src=00 and retires -> boundary.
- WB: write_reg=1, write_pc=1, pc_src=00; retires -> boundary.
- Boundary: run=1 -> FETCH, run=0 -> IDLE. run falling mid-instruction never aborts the instruction.
- Exactly one write_pc pulse per retired instruction; write_reg and write_lr are never both high in the same cycle.
- The timeout counter clears on every state change.
- HALT: halted=1 and all strobes 0. clear=1 -> IDLE with err cleared. clear has no effect in any other state.
- instr_count increments by 1 on each retire cycle and wraps modulo 2^CNT_W.

Optional Feature:
INSTR_COUNT_EN: defined -> CNT_W-bit instruction counter as above. Undefined -> no counter register; instr_count tied to 0.

Decomposition:
- Package cpu_pkg: opcode/funct localparams, state encoding, pc_src and err encodings.
- One sub-module, seq_decode: combinational opcode/funct -> instruction class (alu, jump, branch, load, store, halt, illegal). The FSM stays in multicycle_sequencer.

Test Plan:
- addi (001000), run=1, imem_valid and dmem_ready always 1 -> FETCH, DECODE, EXEC, WB: write_reg and write_pc (pc_src=00) high only in cycle 4; instr_count=1.
- lw with dmem_ready delayed 3 cycles -> dmem_re high 4 cycles, then WB write_reg; sw -> dmem_we, then write_pc, no write_reg.
- beq with br_taken=1 -> pc_src=11; bne with br_taken=0 -> pc_src=00; jal -> write_lr=1 and pc_src=10; jr -> pc_src=01.
- Opcode 010111 -> HALT, err=01, halted=1; clear pulse -> IDLE, err=00. Opcode 111111 -> HALT, err=00.
- MEM_TIMEOUT=4, imem_valid held 0 -> HALT after 4 FETCH cycles, err=10.
- run dropped during MEM -> instruction completes, then IDLE. rstn asserted mid-WB -> immediate IDLE, all outputs 0, instr_count=0.
